// File: rtl/t07_esp_spi_rx.sv
// SPI mode-0 slave: syncs sclk/cs_n/mosi into clk, assembles MSB-first words into a small FIFO.
// Word visible ~3 clk after its last sclk rise; a full FIFO with no pop drops the word (sticky overflow).
module t07_esp_spi_rx #(
  parameter  int WORD_W = 32,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              frame_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] PUSH  = 2'd2;

  logic [2:0]        sclk_s;
  logic [1:0]        cs_s;
  logic [1:0]        mosi_s;
  logic [1:0]        state;
  logic [BC_W-1:0]   bit_cnt;
  logic [WORD_W-1:0] shift_reg;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;

  logic rise, push, pop, full, wr_ok, ov_set, fe_set;

  // mosi is taken from the same stage depth as the sclk edge so their skew is kept
  assign rise   = sclk_s[1] & ~sclk_s[2];
  assign push   = (state == PUSH);
  assign full   = (count == CNT_W'(DEPTH));
  assign pop    = rd_en && (count != '0);
  assign wr_ok  = push && (!full || pop);
  assign ov_set = push && full && !rd_en;
  assign fe_set = (state == SHIFT) && cs_s[1] && (bit_cnt != '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sclk_s    <= '0;
      cs_s      <= '0;
      mosi_s    <= '0;
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      frame_err <= 1'b0;
    end else begin
      sclk_s    <= {sclk_s[1:0], sclk};
      cs_s      <= {cs_s[0], cs_n};
      mosi_s    <= {mosi_s[0], mosi};
      frame_err <= fe_set | (frame_err & ~clr_err);
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!cs_s[1]) state <= SHIFT;
        end
        SHIFT: begin
          // deselect aborts any partial word; fe_set flags it when bits were seen
          if (cs_s[1]) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end else if (rise) begin
            shift_reg <= {shift_reg[WORD_W-2:0], mosi_s[1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= PUSH;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PUSH:    state <= cs_s[1] ? IDLE : SHIFT;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= shift_reg;
  end

  // a push into a full FIFO still succeeds when the head is popped in the same cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= ov_set | (overflow & ~clr_err);
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign data_valid = (count != '0);
  assign data_out   = data_valid ? mem[rd_ptr] : '0;

endmodule
